// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the multi-channel clock divider
package clk_div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MIN_DIV = 2;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, run/idle FSM, pending divide register
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             boundary;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W:0]   half;

  always_comb begin
    state_d    = en_i ? RUN : IDLE;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;
    // Leaving IDLE is a boundary too: cnt sits at div_act-1 there, so the first period is whole.
    boundary   = (state_q == IDLE) || sync_i || (cnt_q == div_act_q - 1'b1);
    if (pend_vld_q && (!en_i || boundary)) begin
      div_act_d  = div_pend_q;
      pend_vld_d = 1'b0;
    end
    nxt  = boundary ? '0 : cnt_q + 1'b1;
    half = ({1'b0, div_act_d} + 1'b1) >> 1;
    if (en_i) begin
      cnt_d     = nxt;
      clk_out_d = ({1'b0, nxt} < half);
      tick_d    = boundary;
    end else begin
      cnt_d = div_act_d - 1'b1;
    end
    if (wr_i) begin
      div_pend_d = wr_div_i;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= DEF_D - 1'b1;
      div_act_q  <= DEF_D;
      div_pend_q <= DEF_D;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_vld_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with shared config port and sync
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 10,
  parameter int CH_W    = ch_w(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   en_i,
  input  logic             sync_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic             cfg_err_o,
  output logic [NCH-1:0]   clk_out_o,
  output logic [NCH-1:0]   tick_o,
  output logic [NCH-1:0]   pend_o
);

  logic [NCH-1:0] ch_sel;
  logic [NCH-1:0] wr;
  logic           ch_ok, div_ok, accept;
  logic           cfg_err_q, cfg_err_d;

  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_sel[i] = (int'(cfg_ch_i) == i);
    end
  end

  assign ch_ok  = |ch_sel;
  assign div_ok = (cfg_div_i >= CNT_W'(MIN_DIV));
  // Out-of-range channels select nothing, so they are always ready and only raise cfg_err.
  assign cfg_ready_o = !rst_i && !(|(ch_sel & pend_o));
  assign accept      = cfg_valid_i && cfg_ready_o;
  assign wr          = {NCH{accept && ch_ok && div_ok}} & ch_sel;
  assign cfg_err_d   = accept && !(ch_ok && div_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err_o = cfg_err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i[g]),
      .sync_i    (sync_i),
      .wr_i      (wr[g]),
      .wr_div_i  (cfg_div_i),
      .clk_out_o (clk_out_o[g]),
      .tick_o    (tick_o[g]),
      .pend_o    (pend_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - randomized self-checking bench with a waveform-queue reference model
module tb_clk_div_multi;

  localparam int NCH     = 3;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 10;
  localparam int CH_W    = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NCH-1:0]   en_i;
  logic             sync_i;
  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [CH_W-1:0]  cfg_ch_i;
  logic [CNT_W-1:0] cfg_div_i;
  logic             cfg_err_o;
  logic [NCH-1:0]   clk_out_o, tick_o, pend_o;

  int checks = 0;
  int errors = 0;

  // Model: each running channel holds the remaining samples of its current period.
  int             m_dact  [NCH];
  int             m_dpend [NCH];
  bit             m_pvld  [NCH];
  int             wave    [NCH][$];
  logic [NCH-1:0] exp_clk, exp_tick, exp_pend;
  logic           exp_err;

  clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .sync_i      (sync_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_err_o   (cfg_err_o),
    .clk_out_o   (clk_out_o),
    .tick_o      (tick_o),
    .pend_o      (pend_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit exp_ready();
    if (rst_i) return 1'b0;
    if (int'(cfg_ch_i) >= NCH) return 1'b1;
    return !m_pvld[cfg_ch_i];
  endfunction

  task automatic step();
    bit acc, bad;
    @(posedge clk_i);
    acc = cfg_valid_i && exp_ready();
    bad = (int'(cfg_ch_i) >= NCH) || (int'(cfg_div_i) < 2);
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        m_dact[i] = DEF_DIV; m_dpend[i] = DEF_DIV; m_pvld[i] = 1'b0;
        wave[i].delete();
        exp_clk[i] = 1'b0; exp_tick[i] = 1'b0;
      end
      exp_err = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        exp_clk[i] = 1'b0; exp_tick[i] = 1'b0;
        if (!en_i[i]) begin
          if (m_pvld[i]) begin m_dact[i] = m_dpend[i]; m_pvld[i] = 1'b0; end
          wave[i].delete();
        end else begin
          if (sync_i || wave[i].size() == 0) begin
            if (m_pvld[i]) begin m_dact[i] = m_dpend[i]; m_pvld[i] = 1'b0; end
            wave[i].delete();
            for (int k = 0; k < m_dact[i]; k++) wave[i].push_back((k < (m_dact[i] + 1) / 2) ? 1 : 0);
            exp_tick[i] = 1'b1;
          end
          exp_clk[i] = (wave[i].pop_front() != 0);
        end
      end
      if (acc && !bad) begin
        m_dpend[cfg_ch_i] = int'(cfg_div_i);
        m_pvld[cfg_ch_i]  = 1'b1;
      end
      exp_err = acc && bad;
    end
    for (int i = 0; i < NCH; i++) exp_pend[i] = m_pvld[i];
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = '0; sync_i = 1'b0; cfg_valid_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0;
    step(); step();
    checks++;
    if ({clk_out_o, tick_o, pend_o, cfg_err_o} !== 10'b0)
      begin errors++; $display("FAIL reset_outputs got clk=%b tick=%b pend=%b err=%b want all 0", clk_out_o, tick_o, pend_o, cfg_err_o); end
    checks++;
    if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cfg_ready_o); end
    rst_i = 1'b0; #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", cfg_ready_o); end
  endtask

  task automatic test_basic();
    en_i = 3'b001;
    for (int k = 1; k <= 25; k++) begin
      step();
      checks++;
      if ({clk_out_o, tick_o, pend_o, cfg_err_o} !== {exp_clk, exp_tick, exp_pend, exp_err})
        begin errors++; $display("FAIL basic_model k=%0d got %b %b %b %b want %b %b %b %b", k, clk_out_o, tick_o, pend_o, cfg_err_o, exp_clk, exp_tick, exp_pend, exp_err); end
      checks++;
      if (tick_o[0] !== 1'(k % 10 == 1) || clk_out_o[0] !== 1'((k - 1) % 10 < 5))
        begin errors++; $display("FAIL basic_div10 k=%0d got tick=%b clk=%b want tick=%b clk=%b", k, tick_o[0], clk_out_o[0], k % 10 == 1, (k - 1) % 10 < 5); end
    end
  endtask

  task automatic test_reprogram();
    int t[$];
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 8'd7; #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL reprog_ready got %b want 1", cfg_ready_o); end
    step();
    checks++;
    if (pend_o[0] !== 1'b1) begin errors++; $display("FAIL reprog_pend got %b want 1", pend_o[0]); end
    cfg_div_i = 8'd5; #1;
    checks++;
    if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL reprog_busy got %b want 0", cfg_ready_o); end
    step();
    cfg_ch_i = 2'd1; cfg_div_i = 8'd6; #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL reprog_other_ready got %b want 1", cfg_ready_o); end
    step();
    cfg_valid_i = 1'b0;
    checks++;
    if (pend_o !== 3'b011) begin errors++; $display("FAIL reprog_pend_both got %b want 011", pend_o); end
    for (int k = 1; k <= 30; k++) begin
      step();
      if (tick_o[0]) t.push_back(k);
      checks++;
      if ({clk_out_o, tick_o, pend_o, cfg_err_o} !== {exp_clk, exp_tick, exp_pend, exp_err})
        begin errors++; $display("FAIL reprog_model k=%0d got %b %b %b %b want %b %b %b %b", k, clk_out_o, tick_o, pend_o, cfg_err_o, exp_clk, exp_tick, exp_pend, exp_err); end
    end
    checks++;
    if (t.size() < 3 || t[0] != 3 || t[1] - t[0] != 7 || t[2] - t[1] != 7)
      begin errors++; $display("FAIL reprog_period ticks=%p want 3,10,17,..", t); end
  endtask

  task automatic test_illegal();
    logic [CH_W-1:0]  chs [3] = '{2'd0, 2'd0, 2'd3};
    logic [CNT_W-1:0] dvs [3] = '{8'd0, 8'd1, 8'd9};
    for (int n = 0; n < 3; n++) begin
      cfg_valid_i = 1'b1; cfg_ch_i = chs[n]; cfg_div_i = dvs[n]; #1;
      checks++;
      if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL illegal_ready n=%0d got %b want 1", n, cfg_ready_o); end
      step();
      cfg_valid_i = 1'b0;
      checks++;
      if (cfg_err_o !== 1'b1 || pend_o !== 3'b000)
        begin errors++; $display("FAIL illegal_err n=%0d got err=%b pend=%b want 1 000", n, cfg_err_o, pend_o); end
      step();
      checks++;
      if ({clk_out_o, tick_o, pend_o, cfg_err_o} !== {exp_clk, exp_tick, exp_pend, exp_err} || cfg_err_o !== 1'b0)
        begin errors++; $display("FAIL illegal_after n=%0d got %b %b %b %b want %b %b %b 0", n, clk_out_o, tick_o, pend_o, cfg_err_o, exp_clk, exp_tick, exp_pend); end
    end
  endtask

  task automatic test_sync();
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 8'd4;
    step();
    cfg_valid_i = 1'b0; en_i = 3'b011;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if ({clk_out_o, tick_o, pend_o, cfg_err_o} !== {exp_clk, exp_tick, exp_pend, exp_err})
        begin errors++; $display("FAIL sync_pre k=%0d got %b %b %b %b want %b %b %b %b", k, clk_out_o, tick_o, pend_o, cfg_err_o, exp_clk, exp_tick, exp_pend, exp_err); end
    end
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    checks++;
    if (tick_o[1:0] !== 2'b11 || clk_out_o[1:0] !== 2'b11)
      begin errors++; $display("FAIL sync_tick got tick=%b clk=%b want 11 11", tick_o[1:0], clk_out_o[1:0]); end
    for (int k = 1; k <= 24; k++) begin
      step();
      checks++;
      if ((tick_o[0] & tick_o[1]) !== 1'(k % 12 == 0) || {clk_out_o, tick_o} !== {exp_clk, exp_tick})
        begin errors++; $display("FAIL sync_align k=%0d got tick=%b clk=%b want tick=%b clk=%b", k, tick_o, clk_out_o, exp_tick, exp_clk); end
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    en_i = 3'b001;
    cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 8'd7;
    step();
    cfg_valid_i = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      got = tick_o[0];
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_wait got no tick want tick within 20 cycles"); end
    step(); step(); step();
    rst_i = 1'b1;
    step();
    checks++;
    if ({clk_out_o, tick_o, pend_o, cfg_err_o} !== 10'b0)
      begin errors++; $display("FAIL rstmid_zero got clk=%b tick=%b pend=%b err=%b want all 0", clk_out_o, tick_o, pend_o, cfg_err_o); end
    rst_i = 1'b0; en_i = 3'b000;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (clk_out_o !== 3'b000 || tick_o !== 3'b000)
        begin errors++; $display("FAIL rstmid_idle k=%0d got clk=%b tick=%b want 000 000", k, clk_out_o, tick_o); end
    end
    en_i = 3'b001;
    step();
    checks++;
    if (tick_o[0] !== 1'b1 || clk_out_o[0] !== 1'b1)
      begin errors++; $display("FAIL rstmid_restart got tick=%b clk=%b want 1 1", tick_o[0], clk_out_o[0]); end
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (tick_o[0] !== 1'(k % 10 == 0) || {clk_out_o, tick_o, pend_o} !== {exp_clk, exp_tick, exp_pend})
        begin errors++; $display("FAIL rstmid_def k=%0d got tick=%b clk=%b want tick=%b clk=%b", k, tick_o, clk_out_o, exp_tick, exp_clk); end
    end
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 1500; k++) begin
      rst_i  = ($urandom_range(0, 399) == 0);
      sync_i = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) en_i[$urandom_range(0, NCH - 1)] ^= 1'b1;
      cfg_valid_i = ($urandom_range(0, 3) == 0);
      cfg_ch_i    = CH_W'($urandom_range(0, 3));
      r = $urandom_range(0, 19);
      cfg_div_i = (r == 0) ? 8'($urandom_range(0, 1)) : (r == 1) ? 8'd255 : 8'($urandom_range(2, 20));
      #1;
      checks++;
      if (cfg_ready_o !== exp_ready())
        begin errors++; $display("FAIL rand_ready k=%0d got %b want %b", k, cfg_ready_o, exp_ready()); end
      step();
      checks++;
      if ({clk_out_o, tick_o, pend_o, cfg_err_o} !== {exp_clk, exp_tick, exp_pend, exp_err})
        begin errors++; $display("FAIL rand_model k=%0d got %b %b %b %b want %b %b %b %b", k, clk_out_o, tick_o, pend_o, cfg_err_o, exp_clk, exp_tick, exp_pend, exp_err); end
    end
    rst_i = 1'b0; sync_i = 1'b0; cfg_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reprogram();
    test_illegal();
    test_sync();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
